// File: rtl/uc_pkg.sv
// Shared encodings for the multicycle control unit: FSM states, ALU codes,
// opcodes and the datapath mux-select / exception-cause values.
package uc_pkg;

    typedef enum logic [3:0] {
        ST_RST    = 4'd0,
        ST_FETCH  = 4'd1,
        ST_DECODE = 4'd2,
        ST_EXEC_R = 4'd3,
        ST_EXEC_I = 4'd4,
        ST_WB_ALU = 4'd5,
        ST_ADDR   = 4'd6,
        ST_MEM_RD = 4'd7,
        ST_MEM_WB = 4'd8,
        ST_MEM_WR = 4'd9,
        ST_BRANCH = 4'd10,
        ST_JAL    = 4'd11,
        ST_LUI    = 4'd12,
        ST_EXCEPT = 4'd13
    } state_t;

    localparam logic [2:0] ALU_NONE = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b001;
    localparam logic [2:0] ALU_SUB  = 3'b010;
    localparam logic [2:0] ALU_AND  = 3'b011;
    localparam logic [2:0] ALU_XOR  = 3'b110;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;

    localparam logic [1:0] SRCA_PC     = 2'b00;
    localparam logic [1:0] SRCA_A      = 2'b01;
    localparam logic [1:0] SRCA_OLDPC  = 2'b10;
    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_4      = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_EXC    = 2'b11;

    localparam logic [1:0] M2R_ALUOUT = 2'b00;
    localparam logic [1:0] M2R_MDR    = 2'b01;
    localparam logic [1:0] M2R_PC     = 2'b10;
    localparam logic [1:0] M2R_IMM    = 2'b11;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

    function automatic logic is_mem_state(input state_t s);
        return (s == ST_FETCH) || (s == ST_MEM_RD) || (s == ST_MEM_WR);
    endfunction

endpackage

// File: rtl/uc_alu_dec.sv
// Combinational ALU operation decode from FUNCT3/FUNCT7_5.
// Immediate-form instructions ignore FUNCT7_5 (there is no subi).
module uc_alu_dec
    import uc_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic       is_imm,
    output logic [2:0] alu_sel
);

    always_comb begin
        alu_sel = ALU_ADD;
        case (funct3)
            3'b000:  alu_sel = (funct7_5 && !is_imm) ? ALU_SUB : ALU_ADD;
            3'b111:  alu_sel = ALU_AND;
            3'b100:  alu_sel = ALU_XOR;
            default: alu_sel = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/uc_multiciclo_param.sv
// Multicycle control unit for the 64-bit RISC-V datapath: memory handshake
// with bounded wait, branch/jal/lui/load/store sequencing and exception entry.
module uc_multiciclo_param
    import uc_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int EXC_ENABLE  = 1,
    parameter int CNT_W       = 8
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [6:0] IR6_0,
    input  logic [2:0] FUNCT3,
    input  logic       FUNCT7_5,
    input  logic       ALU_ZERO,
    input  logic       MEM_READY,
    output logic       MEM_REQ,
    output logic       MEM32_WIRE,
    output logic       IR_WIRE,
    output logic       LOAD_A,
    output logic       LOAD_B,
    output logic       LOAD_ALUOUT,
    output logic       LOAD_MDR,
    output logic       LOAD_OLDPC,
    output logic [1:0] ALU_SRCA,
    output logic [1:0] ALU_SRCB,
    output logic [2:0] ALU_SELECTOR,
    output logic       PC_WRITE,
    output logic [1:0] PC_SRC,
    output logic [1:0] MEM_TO_REG,
    output logic       BANCO_WIRE,
    output logic       EPC_WRITE,
    output logic [1:0] CAUSE,
    output logic [3:0] STATE_DBG
);

    state_t           state_q, state_nxt;
    logic [CNT_W-1:0] cnt_q;
    logic             first_q;
    logic [1:0]       cause_q, cause_nxt;
    logic [2:0]       dec_sel;
    logic             timeout;

    uc_alu_dec u_alu_dec (
        .funct3   (FUNCT3),
        .funct7_5 (FUNCT7_5),
        .is_imm   (state_q == ST_EXEC_I),
        .alu_sel  (dec_sel)
    );

    // The limit is hit on the cycle the counter would reach MEM_TIMEOUT; a
    // MEM_READY in that same cycle still completes the access.
    assign timeout = (EXC_ENABLE != 0) && !MEM_READY &&
                     (cnt_q == CNT_W'(MEM_TIMEOUT - 1));

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= ST_RST;
            cnt_q   <= '0;
            first_q <= 1'b0;
            cause_q <= CAUSE_NONE;
        end else begin
            state_q <= state_nxt;
            first_q <= (state_nxt != state_q);
            if (state_nxt != state_q)
                cnt_q <= '0;
            else if (is_mem_state(state_q) && !MEM_READY && (cnt_q != '1))
                cnt_q <= cnt_q + 1'b1;
            if (state_nxt == ST_EXCEPT)
                cause_q <= cause_nxt;
        end
    end

    always_comb begin
        state_nxt    = state_q;
        cause_nxt    = cause_q;
        MEM_REQ      = 1'b0;
        MEM32_WIRE   = 1'b0;
        IR_WIRE      = 1'b0;
        LOAD_A       = 1'b0;
        LOAD_B       = 1'b0;
        LOAD_ALUOUT  = 1'b0;
        LOAD_MDR     = 1'b0;
        LOAD_OLDPC   = 1'b0;
        ALU_SRCA     = SRCA_PC;
        ALU_SRCB     = SRCB_B;
        ALU_SELECTOR = ALU_NONE;
        PC_WRITE     = 1'b0;
        PC_SRC       = PCSRC_ALU;
        MEM_TO_REG   = M2R_ALUOUT;
        BANCO_WIRE   = 1'b0;
        EPC_WRITE    = 1'b0;
        case (state_q)
            ST_RST: state_nxt = ST_FETCH;
            ST_FETCH: begin
                MEM_REQ      = 1'b1;
                LOAD_OLDPC   = first_q;
                ALU_SRCA     = SRCA_PC;
                ALU_SRCB     = SRCB_4;
                ALU_SELECTOR = ALU_ADD;
                if (MEM_READY) begin
                    IR_WIRE   = 1'b1;
                    PC_WRITE  = 1'b1;
                    state_nxt = ST_DECODE;
                end else if (timeout) begin
                    cause_nxt = CAUSE_TIMEOUT;
                    state_nxt = ST_EXCEPT;
                end
            end
            ST_DECODE: begin
                LOAD_A       = 1'b1;
                LOAD_B       = 1'b1;
                LOAD_ALUOUT  = 1'b1;
                ALU_SRCA     = SRCA_OLDPC;
                ALU_SRCB     = SRCB_IMM_SH;
                ALU_SELECTOR = ALU_ADD;
                case (IR6_0)
                    OP_R:              state_nxt = ST_EXEC_R;
                    OP_I:              state_nxt = ST_EXEC_I;
                    OP_LOAD, OP_STORE: state_nxt = ST_ADDR;
                    OP_BRANCH:         state_nxt = ST_BRANCH;
                    OP_JAL:            state_nxt = ST_JAL;
                    OP_LUI:            state_nxt = ST_LUI;
                    default: begin
                        if (EXC_ENABLE != 0) begin
                            cause_nxt = CAUSE_ILLEGAL;
                            state_nxt = ST_EXCEPT;
                        end else begin
                            state_nxt = ST_FETCH;
                        end
                    end
                endcase
            end
            ST_EXEC_R, ST_EXEC_I: begin
                ALU_SRCA     = SRCA_A;
                ALU_SRCB     = (state_q == ST_EXEC_I) ? SRCB_IMM : SRCB_B;
                ALU_SELECTOR = dec_sel;
                LOAD_ALUOUT  = 1'b1;
                state_nxt    = ST_WB_ALU;
            end
            ST_WB_ALU: begin
                BANCO_WIRE = 1'b1;
                MEM_TO_REG = M2R_ALUOUT;
                state_nxt  = ST_FETCH;
            end
            ST_ADDR: begin
                ALU_SRCA     = SRCA_A;
                ALU_SRCB     = SRCB_IMM;
                ALU_SELECTOR = ALU_ADD;
                LOAD_ALUOUT  = 1'b1;
                state_nxt    = (IR6_0 == OP_LOAD) ? ST_MEM_RD : ST_MEM_WR;
            end
            ST_MEM_RD, ST_MEM_WR: begin
                MEM_REQ    = 1'b1;
                MEM32_WIRE = (state_q == ST_MEM_WR);
                if (MEM_READY) begin
                    LOAD_MDR  = (state_q == ST_MEM_RD);
                    state_nxt = (state_q == ST_MEM_RD) ? ST_MEM_WB : ST_FETCH;
                end else if (timeout) begin
                    cause_nxt = CAUSE_TIMEOUT;
                    state_nxt = ST_EXCEPT;
                end
            end
            ST_MEM_WB: begin
                BANCO_WIRE = 1'b1;
                MEM_TO_REG = M2R_MDR;
                state_nxt  = ST_FETCH;
            end
            ST_BRANCH: begin
                ALU_SRCA     = SRCA_A;
                ALU_SRCB     = SRCB_B;
                ALU_SELECTOR = ALU_SUB;
                if (((FUNCT3 == F3_BEQ) && ALU_ZERO) || ((FUNCT3 == F3_BNE) && !ALU_ZERO)) begin
                    PC_WRITE = 1'b1;
                    PC_SRC   = PCSRC_ALUOUT;
                end
                state_nxt = ST_FETCH;
            end
            ST_JAL: begin
                BANCO_WIRE = 1'b1;
                MEM_TO_REG = M2R_PC;
                PC_WRITE   = 1'b1;
                PC_SRC     = PCSRC_ALUOUT;
                state_nxt  = ST_FETCH;
            end
            ST_LUI: begin
                BANCO_WIRE = 1'b1;
                MEM_TO_REG = M2R_IMM;
                state_nxt  = ST_FETCH;
            end
            ST_EXCEPT: begin
                EPC_WRITE = 1'b1;
                PC_WRITE  = 1'b1;
                PC_SRC    = PCSRC_EXC;
                state_nxt = ST_FETCH;
            end
            default: state_nxt = ST_RST;
        endcase
    end

    assign CAUSE     = cause_q;
    assign STATE_DBG = state_q;

endmodule

// File: tb/tb_uc_multiciclo_param.sv
// Directed bench for uc_multiciclo_param: one instance with exceptions enabled
// and one with them disabled, driven in lockstep from shared inputs.
module tb_uc_multiciclo_param;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ir;
    logic        alu_zero;
    logic        mem_ready;
    logic [6:0]  ir6_0;
    logic [2:0]  funct3;
    logic        funct7_5;

    assign ir6_0    = ir[6:0];
    assign funct3   = ir[14:12];
    assign funct7_5 = ir[30];

    always #5 clk = ~clk;

    logic       mem_req, mem32_wire, ir_wire, load_a, load_b, load_aluout, load_mdr, load_oldpc;
    logic [1:0] alu_srca, alu_srcb, pc_src, mem_to_reg, cause;
    logic [2:0] alu_selector;
    logic       pc_write, banco_wire, epc_write;
    logic [3:0] state_dbg;

    logic       mem_req0, mem32_wire0, ir_wire0, load_a0, load_b0, load_aluout0, load_mdr0, load_oldpc0;
    logic [1:0] alu_srca0, alu_srcb0, pc_src0, mem_to_reg0, cause0;
    logic [2:0] alu_selector0;
    logic       pc_write0, banco_wire0, epc_write0;
    logic [3:0] state_dbg0;

    uc_multiciclo_param #(.MEM_TIMEOUT(16), .EXC_ENABLE(1), .CNT_W(8)) dut (
        .CLK(clk), .RESET(rst), .IR6_0(ir6_0), .FUNCT3(funct3), .FUNCT7_5(funct7_5),
        .ALU_ZERO(alu_zero), .MEM_READY(mem_ready),
        .MEM_REQ(mem_req), .MEM32_WIRE(mem32_wire), .IR_WIRE(ir_wire),
        .LOAD_A(load_a), .LOAD_B(load_b), .LOAD_ALUOUT(load_aluout), .LOAD_MDR(load_mdr),
        .LOAD_OLDPC(load_oldpc), .ALU_SRCA(alu_srca), .ALU_SRCB(alu_srcb),
        .ALU_SELECTOR(alu_selector), .PC_WRITE(pc_write), .PC_SRC(pc_src),
        .MEM_TO_REG(mem_to_reg), .BANCO_WIRE(banco_wire), .EPC_WRITE(epc_write),
        .CAUSE(cause), .STATE_DBG(state_dbg)
    );

    uc_multiciclo_param #(.MEM_TIMEOUT(16), .EXC_ENABLE(0), .CNT_W(8)) dut0 (
        .CLK(clk), .RESET(rst), .IR6_0(ir6_0), .FUNCT3(funct3), .FUNCT7_5(funct7_5),
        .ALU_ZERO(alu_zero), .MEM_READY(mem_ready),
        .MEM_REQ(mem_req0), .MEM32_WIRE(mem32_wire0), .IR_WIRE(ir_wire0),
        .LOAD_A(load_a0), .LOAD_B(load_b0), .LOAD_ALUOUT(load_aluout0), .LOAD_MDR(load_mdr0),
        .LOAD_OLDPC(load_oldpc0), .ALU_SRCA(alu_srca0), .ALU_SRCB(alu_srcb0),
        .ALU_SELECTOR(alu_selector0), .PC_WRITE(pc_write0), .PC_SRC(pc_src0),
        .MEM_TO_REG(mem_to_reg0), .BANCO_WIRE(banco_wire0), .EPC_WRITE(epc_write0),
        .CAUSE(cause0), .STATE_DBG(state_dbg0)
    );

    logic [27:0] all_out;
    assign all_out = {mem_req, mem32_wire, ir_wire, load_a, load_b, load_aluout, load_mdr,
                      load_oldpc, alu_srca, alu_srcb, alu_selector, pc_write, pc_src,
                      mem_to_reg, banco_wire, epc_write, cause, state_dbg};

    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Called in a FETCH cycle: memory answers at once, then lands in DECODE.
    task automatic do_fetch(input logic [31:0] instr);
        ir = instr;
        mem_ready = 1'b1;
        #1;
        chk("fetch_state", state_dbg, 32'd1);
        chk("fetch_ir_wire", ir_wire, 32'd1);
        cyc();
        mem_ready = 1'b0;
        #1;
        chk("decode_state", state_dbg, 32'd2);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; ir = 32'h0; alu_zero = 1'b0; mem_ready = 1'b0;
        cyc(); cyc();
        chk("reset_all_out", all_out, 32'd0);

        // release reset: first edge goes to FETCH
        rst = 1'b0;
        cyc();
        chk("rel_state", state_dbg, 32'd1);
        chk("rel_mem_req", mem_req, 32'd1);
        chk("rel_oldpc", load_oldpc, 32'd1);
        chk("rel_ir_wire", ir_wire, 32'd0);
        cyc();
        chk("wait_state", state_dbg, 32'd1);
        chk("oldpc_once", load_oldpc, 32'd0);

        // add x3,x1,x2
        ir = 32'h002081B3; mem_ready = 1'b1; #1;
        chk("add_pc_write", pc_write, 32'd1);
        chk("add_srcb", alu_srcb, 32'd1);
        chk("add_fetch_alu", alu_selector, 32'd1);
        cyc(); mem_ready = 1'b0; #1;
        chk("add_dec_state", state_dbg, 32'd2);
        chk("add_dec_load_a", load_a, 32'd1);
        chk("add_dec_srca", alu_srca, 32'd2);
        chk("add_dec_srcb", alu_srcb, 32'd3);
        cyc();
        chk("add_exec_state", state_dbg, 32'd3);
        chk("add_exec_alu", alu_selector, 32'd1);
        chk("add_exec_aluout", load_aluout, 32'd1);
        cyc();
        chk("add_wb_state", state_dbg, 32'd5);
        chk("add_wb_banco", banco_wire, 32'd1);
        chk("add_wb_m2r", mem_to_reg, 32'd0);
        cyc();

        // sub, xor (R) and addi with bit30 set, andi (I)
        do_fetch(32'h40208133); cyc();
        chk("sub_alu", alu_selector, 32'd2);
        cyc(); cyc();
        do_fetch(32'h0020C1B3); cyc();
        chk("xor_alu", alu_selector, 32'd6);
        cyc(); cyc();
        do_fetch(32'h40008093); cyc();
        chk("addi_state", state_dbg, 32'd4);
        chk("addi_alu", alu_selector, 32'd1);
        chk("addi_srcb", alu_srcb, 32'd2);
        cyc(); cyc();
        do_fetch(32'h0000F093); cyc();
        chk("andi_alu", alu_selector, 32'd3);
        cyc(); cyc();

        // ld with MEM_READY delayed 3 cycles
        do_fetch(32'h00003003); cyc();
        chk("ld_addr_state", state_dbg, 32'd6);
        chk("ld_addr_srcb", alu_srcb, 32'd2);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("ld_wait_state", state_dbg, 32'd7);
            chk("ld_wait_req", mem_req, 32'd1);
            chk("ld_wait_mdr", load_mdr, 32'd0);
        end
        cyc(); mem_ready = 1'b1; #1;
        chk("ld_rdy_req", mem_req, 32'd1);
        chk("ld_rdy_mdr", load_mdr, 32'd1);
        cyc(); mem_ready = 1'b0; #1;
        chk("ld_wb_state", state_dbg, 32'd8);
        chk("ld_wb_banco", banco_wire, 32'd1);
        chk("ld_wb_m2r", mem_to_reg, 32'd1);
        chk("ld_wb_mdr", load_mdr, 32'd0);
        cyc();
        chk("ld_done_state", state_dbg, 32'd1);

        // sd
        do_fetch(32'h00003023); cyc(); cyc();
        mem_ready = 1'b1; #1;
        chk("sd_state", state_dbg, 32'd9);
        chk("sd_req", mem_req, 32'd1);
        chk("sd_we", mem32_wire, 32'd1);
        cyc(); mem_ready = 1'b0; #1;
        chk("sd_done_state", state_dbg, 32'd1);

        // beq / bne, taken and not taken
        do_fetch(32'h00000063); cyc();
        alu_zero = 1'b1; #1;
        chk("beq_z_state", state_dbg, 32'd10);
        chk("beq_z_alu", alu_selector, 32'd2);
        chk("beq_z_pcw", pc_write, 32'd1);
        chk("beq_z_pcsrc", pc_src, 32'd1);
        cyc();
        do_fetch(32'h00000063); cyc();
        alu_zero = 1'b0; #1;
        chk("beq_nz_pcw", pc_write, 32'd0);
        cyc();
        do_fetch(32'h00001063); cyc();
        alu_zero = 1'b0; #1;
        chk("bne_nz_pcw", pc_write, 32'd1);
        chk("bne_nz_pcsrc", pc_src, 32'd1);
        cyc();
        do_fetch(32'h00001063); cyc();
        alu_zero = 1'b1; #1;
        chk("bne_z_pcw", pc_write, 32'd0);
        cyc(); alu_zero = 1'b0;

        // jal, lui
        do_fetch(32'h0000006F); cyc();
        chk("jal_state", state_dbg, 32'd11);
        chk("jal_banco", banco_wire, 32'd1);
        chk("jal_m2r", mem_to_reg, 32'd2);
        chk("jal_pcw", pc_write, 32'd1);
        chk("jal_pcsrc", pc_src, 32'd1);
        cyc();
        do_fetch(32'h00000037); cyc();
        chk("lui_state", state_dbg, 32'd12);
        chk("lui_banco", banco_wire, 32'd1);
        chk("lui_m2r", mem_to_reg, 32'd3);
        chk("lui_pcw", pc_write, 32'd0);
        cyc();

        // illegal opcode 0x7F
        do_fetch(32'h0000007F); cyc();
        chk("ill_state", state_dbg, 32'd13);
        chk("ill_cause", cause, 32'd1);
        chk("ill_epc", epc_write, 32'd1);
        chk("ill_pcw", pc_write, 32'd1);
        chk("ill_pcsrc", pc_src, 32'd3);
        chk("ill0_state", state_dbg0, 32'd1);
        chk("ill0_writes", {pc_write0, epc_write0, banco_wire0}, 32'd0);
        chk("ill0_cause", cause0, 32'd0);
        cyc();
        chk("ill_back_fetch", state_dbg, 32'd1);
        chk("ill_cause_held", cause, 32'd1);

        // no MEM_READY for 16 FETCH cycles -> timeout exception
        for (int i = 0; i < 15; i++) cyc();
        chk("to_c16_state", state_dbg, 32'd1);
        cyc();
        chk("to_state", state_dbg, 32'd13);
        chk("to_cause", cause, 32'd2);
        chk("to_epc", epc_write, 32'd1);
        chk("to0_state", state_dbg0, 32'd1);
        cyc();
        chk("to_cause_held", cause, 32'd2);

        // MEM_READY exactly on cycle 16 wins
        for (int i = 0; i < 15; i++) cyc();
        do_fetch(32'h002081B3);
        chk("rdy16_state0", state_dbg0, 32'd2);

        // reset in the middle of EXEC_R
        cyc();
        chk("mid_exec_state", state_dbg, 32'd3);
        rst = 1'b1; #1;
        chk("mid_rst_all_out", all_out, 32'd0);
        cyc();
        rst = 1'b0;
        cyc();
        chk("mid_rel_state", state_dbg, 32'd1);
        chk("mid_rel_req", mem_req, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
